bus_arbiter2: RTL and testbench

//  Two-master arbiter between bus masters (Algol core = M0, loader/DMA = M1) and mux_switch master port.

---
 rtl/bus_arbiter2.sv | 123 ++++++++++++
 tb/tb_bus_arbiter2.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter2.sv
// Two-master round-robin arbiter in front of a single slave port.
// One transaction in flight; a watchdog forces an error if the slave never answers.
module bus_arbiter2 #(
  parameter int TIMEOUT = 256,
  parameter int TO_W    = 9
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] m0_address,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wsel,
  input  logic        m0_valid,
  output logic [31:0] m0_rdata,
  output logic        m0_ready,
  output logic        m0_error,
  input  logic [31:0] m1_address,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wsel,
  input  logic        m1_valid,
  output logic [31:0] m1_rdata,
  output logic        m1_ready,
  output logic        m1_error,
  output logic [31:0] slave_address,
  output logic [31:0] slave_wdata,
  output logic [3:0]  slave_wsel,
  output logic        slave_valid,
  input  logic [31:0] slave_rdata,
  input  logic        slave_ready,
  input  logic        slave_error
);
  typedef enum logic {IDLE, BUSY} state_t;

  typedef struct packed {
    logic [31:0] address;
    logic [31:0] wdata;
    logic [3:0]  wsel;
    logic        valid;
  } req_t;

  localparam logic [TO_W-1:0] TO_LAST = (TIMEOUT == 0) ? '0 : TO_W'(TIMEOUT - 1);

  state_t          state_q, state_d;
  logic            grant_q, grant_d;
  logic            last_q,  last_d;
  logic [TO_W-1:0] tcnt_q,  tcnt_d;

  req_t [1:0] req;
  req_t       gnt_req;
  logic [1:0] rdy, err;

  assign req[0]  = {m0_address, m0_wdata, m0_wsel, m0_valid};
  assign req[1]  = {m1_address, m1_wdata, m1_wsel, m1_valid};
  assign gnt_req = req[grant_q];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= 1'b0;
      last_q  <= 1'b1;
      tcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      tcnt_q  <= tcnt_d;
    end
  end

  // Outputs are held quiet while rst is high so a reset mid-transaction emits no response.
  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    last_d        = last_q;
    tcnt_d        = tcnt_q;
    slave_address = '0;
    slave_wdata   = '0;
    slave_wsel    = '0;
    slave_valid   = 1'b0;
    rdy           = '0;
    err           = '0;
    if (!rst) begin
      case (state_q)
        IDLE: begin
          if (m0_valid || m1_valid) begin
            grant_d = (m0_valid && m1_valid) ? ~last_q : m1_valid;
            state_d = BUSY;
            tcnt_d  = '0;
          end
        end
        BUSY: begin
          slave_address = gnt_req.address;
          slave_wdata   = gnt_req.wdata;
          slave_wsel    = gnt_req.wsel;
          slave_valid   = gnt_req.valid;
          if (!gnt_req.valid) begin
            state_d = IDLE;
            last_d  = grant_q;
          end else if (slave_ready || slave_error) begin
            rdy[grant_q] = slave_ready;
            err[grant_q] = slave_error;
            state_d      = IDLE;
            last_d       = grant_q;
          end else if (TIMEOUT != 0 && tcnt_q == TO_LAST) begin
            err[grant_q] = 1'b1;
            slave_valid  = 1'b0;
            state_d      = IDLE;
            last_d       = grant_q;
          end else begin
            tcnt_d = tcnt_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign m0_ready = rdy[0];
  assign m0_error = err[0];
  assign m1_ready = rdy[1];
  assign m1_error = err[1];
  assign m0_rdata = slave_rdata;
  assign m1_rdata = slave_rdata;
endmodule

// File: tb/tb_bus_arbiter2.sv
// Directed bench for bus_arbiter2: inputs driven and outputs checked on the falling edge.
module tb_bus_arbiter2;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] m0_address, m0_wdata, m0_rdata;
  logic [3:0]  m0_wsel;
  logic        m0_valid, m0_ready, m0_error;
  logic [31:0] m1_address, m1_wdata, m1_rdata;
  logic [3:0]  m1_wsel;
  logic        m1_valid, m1_ready, m1_error;
  logic [31:0] slave_address, slave_wdata, slave_rdata;
  logic [3:0]  slave_wsel;
  logic        slave_valid, slave_ready, slave_error;

  int checks = 0;
  int errors = 0;

  bus_arbiter2 #(.TIMEOUT(16), .TO_W(5)) dut (
    .clk(clk), .rst(rst),
    .m0_address(m0_address), .m0_wdata(m0_wdata), .m0_wsel(m0_wsel), .m0_valid(m0_valid),
    .m0_rdata(m0_rdata), .m0_ready(m0_ready), .m0_error(m0_error),
    .m1_address(m1_address), .m1_wdata(m1_wdata), .m1_wsel(m1_wsel), .m1_valid(m1_valid),
    .m1_rdata(m1_rdata), .m1_ready(m1_ready), .m1_error(m1_error),
    .slave_address(slave_address), .slave_wdata(slave_wdata), .slave_wsel(slave_wsel),
    .slave_valid(slave_valid), .slave_rdata(slave_rdata), .slave_ready(slave_ready),
    .slave_error(slave_error)
  );

  always #5 clk = ~clk;

  task automatic idle_inputs();
    m0_address = '0; m0_wdata = '0; m0_wsel = '0; m0_valid = 1'b0;
    m1_address = '0; m1_wdata = '0; m1_wsel = '0; m1_valid = 1'b0;
    slave_rdata = '0; slave_ready = 1'b0; slave_error = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1; idle_inputs();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk); rst = 1'b1; idle_inputs();
    repeat (2) @(negedge clk);
    #1;
    checks++; if (slave_valid !== 1'b0) begin errors++; $display("FAIL rst_slave_valid got %0b exp 0", slave_valid); end
    checks++; if (slave_address !== 32'h0) begin errors++; $display("FAIL rst_slave_address got %h exp 0", slave_address); end
    checks++; if ({m0_ready, m0_error, m1_ready, m1_error} !== 4'b0) begin errors++;
      $display("FAIL rst_resp got %b exp 0000", {m0_ready, m0_error, m1_ready, m1_error}); end
    rst = 1'b0;
  endtask

  task automatic test_read();
    do_reset();
    m0_address = 32'h1000_0004; m0_valid = 1'b1;
    #1;
    checks++; if (slave_valid !== 1'b0) begin errors++; $display("FAIL rd_idle_valid got %0b exp 0", slave_valid); end
    @(negedge clk); #1;
    checks++; if (slave_valid !== 1'b1) begin errors++; $display("FAIL rd_slave_valid got %0b exp 1", slave_valid); end
    checks++; if (slave_address !== 32'h1000_0004) begin errors++; $display("FAIL rd_slave_address got %h exp 10000004", slave_address); end
    checks++; if (slave_wsel !== 4'h0) begin errors++; $display("FAIL rd_slave_wsel got %h exp 0", slave_wsel); end
    @(negedge clk); #1;
    checks++; if (m0_ready !== 1'b0) begin errors++; $display("FAIL rd_early_ready got %0b exp 0", m0_ready); end
    @(negedge clk); slave_ready = 1'b1; slave_rdata = 32'hDEAD_BEEF; #1;
    checks++; if (m0_ready !== 1'b1) begin errors++; $display("FAIL rd_m0_ready got %0b exp 1", m0_ready); end
    checks++; if (m0_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rd_m0_rdata got %h exp deadbeef", m0_rdata); end
    checks++; if (m1_ready !== 1'b0) begin errors++; $display("FAIL rd_m1_ready got %0b exp 0", m1_ready); end
    @(negedge clk); m0_valid = 1'b0; slave_ready = 1'b0; #1;
    checks++; if (m0_ready !== 1'b0) begin errors++; $display("FAIL rd_ready_pulse got %0b exp 0", m0_ready); end
  endtask

  task automatic test_contention();
    logic exp_g;
    logic [31:0] exp_a;
    do_reset();
    m0_address = 32'hA000_0000; m1_address = 32'hB000_0000;
    m0_valid = 1'b1; m1_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_g = i[0];
      exp_a = exp_g ? 32'hB000_0000 : 32'hA000_0000;
      #1;
      checks++; if (slave_valid !== 1'b0) begin errors++; $display("FAIL rr_dead_cycle%0d got %0b exp 0", i, slave_valid); end
      @(negedge clk); slave_ready = 1'b1; #1;
      checks++; if (slave_address !== exp_a) begin errors++; $display("FAIL rr_grant%0d got %h exp %h", i, slave_address, exp_a); end
      checks++; if ({m1_ready, m0_ready} !== (exp_g ? 2'b10 : 2'b01)) begin errors++;
        $display("FAIL rr_ready%0d got %b exp %b", i, {m1_ready, m0_ready}, exp_g ? 2'b10 : 2'b01); end
      @(negedge clk); slave_ready = 1'b0;
    end
    idle_inputs();
  endtask

  task automatic test_write_error();
    do_reset();
    m1_address = 32'h2001_0000; m1_wdata = 32'h41; m1_wsel = 4'hF; m1_valid = 1'b1;
    @(negedge clk); slave_error = 1'b1; #1;
    checks++; if (slave_wdata !== 32'h41 || slave_wsel !== 4'hF || slave_address !== 32'h2001_0000) begin errors++;
      $display("FAIL wr_fwd got %h/%h/%h exp 20010000/41/f", slave_address, slave_wdata, slave_wsel); end
    checks++; if ({m1_error, m1_ready, m0_error} !== 3'b100) begin errors++;
      $display("FAIL wr_err got %b exp 100", {m1_error, m1_ready, m0_error}); end
    @(negedge clk); slave_error = 1'b0; #1;
    checks++; if (slave_valid !== 1'b0 || m1_error !== 1'b0) begin errors++;
      $display("FAIL wr_idle got valid=%0b err=%0b exp 0 0", slave_valid, m1_error); end
    idle_inputs();
    repeat (2) @(negedge clk);
  endtask

  task automatic test_timeout();
    do_reset();
    m0_address = 32'h3000_0000; m0_valid = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk); #1;
      checks++; if (slave_valid !== 1'b1 || m0_error !== 1'b0) begin errors++;
        $display("FAIL to_busy%0d got valid=%0b err=%0b exp 1 0", k, slave_valid, m0_error); end
    end
    @(negedge clk); #1;
    checks++; if (m0_error !== 1'b1 || m0_ready !== 1'b0) begin errors++;
      $display("FAIL to_error got err=%0b rdy=%0b exp 1 0", m0_error, m0_ready); end
    checks++; if (slave_valid !== 1'b0) begin errors++; $display("FAIL to_slave_valid got %0b exp 0", slave_valid); end
    @(negedge clk); m0_valid = 1'b0; #1;
    checks++; if (m0_error !== 1'b0) begin errors++; $display("FAIL to_err_pulse got %0b exp 0", m0_error); end
    @(negedge clk); m0_valid = 1'b1;
    repeat (15) @(negedge clk);
    @(negedge clk); slave_ready = 1'b1; #1;
    checks++; if (m0_ready !== 1'b1 || m0_error !== 1'b0) begin errors++;
      $display("FAIL to_ready_wins got rdy=%0b err=%0b exp 1 0", m0_ready, m0_error); end
    @(negedge clk); idle_inputs();
  endtask

  task automatic test_reset_mid();
    do_reset();
    m0_address = 32'hA000_0000; m1_address = 32'hB000_0000; m1_valid = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1; slave_ready = 1'b1; #1;
    checks++; if ({m1_ready, m1_error} !== 2'b00) begin errors++;
      $display("FAIL rm_resp got %b exp 00", {m1_ready, m1_error}); end
    @(negedge clk); rst = 1'b0; m1_valid = 1'b0; slave_ready = 1'b0; #1;
    checks++; if (slave_valid !== 1'b0) begin errors++; $display("FAIL rm_slave_valid got %0b exp 0", slave_valid); end
    m0_valid = 1'b1; m1_valid = 1'b1;
    @(negedge clk); #1;
    checks++; if (slave_address !== 32'hA000_0000) begin errors++; $display("FAIL rm_tie_m0 got %h exp a0000000", slave_address); end
    m0_valid = 1'b0; m1_valid = 1'b0;
    @(negedge clk); idle_inputs();
  endtask

  task automatic test_drop();
    do_reset();
    m0_address = 32'hA000_0000; m1_address = 32'hB000_0000;
    m0_valid = 1'b1; m1_valid = 1'b1;
    @(negedge clk); m0_valid = 1'b0; #1;
    checks++; if ({m0_ready, m0_error, slave_valid} !== 3'b000) begin errors++;
      $display("FAIL dr_busy got %b exp 000", {m0_ready, m0_error, slave_valid}); end
    @(negedge clk); #1;
    checks++; if (slave_valid !== 1'b0) begin errors++; $display("FAIL dr_idle got %0b exp 0", slave_valid); end
    @(negedge clk); slave_ready = 1'b1; #1;
    checks++; if (slave_address !== 32'hB000_0000 || slave_valid !== 1'b1) begin errors++;
      $display("FAIL dr_m1_grant got %h/%0b exp b0000000/1", slave_address, slave_valid); end
    checks++; if ({m1_ready, m0_ready} !== 2'b10) begin errors++; $display("FAIL dr_m1_ready got %b exp 10", {m1_ready, m0_ready}); end
    @(negedge clk); idle_inputs();
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_read();
    test_contention();
    test_write_error();
    test_timeout();
    test_reset_mid();
    test_drop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
